note_length_sequencer: RTL and testbench
========================================

Name: note_length_sequencer

Overview:
- Successor to the keyboard length decoder for the DE2 synthesizer.
- Consumes the PS/2 scan-code byte stream and tracks make/break/extended prefixes, so key releases and extended keys cannot change the selection.
- Holds the selected note-length index in a register and times each note from a start pulse to an active window and a done pulse.
- Sits between the PS/2 receiver and the note/envelope generator.

Parameters:
- NUM_LEN, 8, number of selectable lengths (1..8); digit keys 1..NUM_LEN are mapped.
- LEN_W, 3, width of length index; must satisfy 2^LEN_W >= NUM_LEN.
- DEFAULT_IDX, 3, index loaded at reset (quarter note).
- TICK_DIV, 12500, clock cycles per duration tick (>=1).
- BASE_TICKS, 25, ticks for the shortest length (idx NUM_LEN-1).

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- scan_code  input  8  PS/2 byte from receiver
- scan_valid  input  1  one-cycle strobe, scan_code valid
- note_start  input  1  one-cycle pulse, begin timing a note
- length_idx  output  LEN_W  currently selected length
- len_update  output  1  one-cycle pulse when length_idx changes via key
- note_active  output  1  high while a note is being timed
- note_done  output  1  one-cycle pulse at end of note

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on resetn.
- Reset values: length_idx=DEFAULT_IDX; len_update=0; note_active=0; note_done=0; prefix FSM=IDLE; all counters 0.
- Prefix FSM (advances only on scan_valid):
  - IDLE: byte F0 goes to BRK; byte E0 goes to EXT; any other byte is a make code and stays in IDLE.
  - BRK: any byte returns to IDLE; the byte is discarded as a break code.
  - EXT: F0 goes to EXT_BRK; any other byte returns to IDLE and is discarded as an extended make.
  - EXT_BRK: any byte returns to IDLE and is discarded.
- Key map, make codes in IDLE only: 16→0, 1E→1, 26→2, 25→3, 2E→4, 36→5, 3D→6, 3E→7.
- Index update:
  - A mapped index below NUM_LEN updates length_idx on the next edge, with a len_update pulse in that same cycle.
  - Unmapped codes, and indices >= NUM_LEN, leave length_idx held. There is no default to 0.
  - Re-pressing the current key still pulses len_update.
- Duration:
  - ticks = BASE_TICKS << (NUM_LEN-1-idx), so idx 0 is the longest.
  - Counter width is sized from the maximum, BASE_TICKS<<(NUM_LEN-1), times TICK_DIV. No overflow is permitted.
- Timer:
  - note_start latches the duration from the current length_idx.
  - note_active rises on the next edge and stays high exactly ticks*TICK_DIV cycles.
  - On the final cycle, note_active falls on the following edge and note_done pulses in the same cycle.
  - The prescaler restarts at each note_start.
- Simultaneous events and boundaries:
  - note_start while active retriggers: the counter reloads from the current length_idx, note_done does not pulse, and note_active stays high.
  - A length change mid-note does not affect the running note.
  - note_start and a key update in the same cycle: the timer uses the old length_idx.
  - note_start in the same cycle as the terminal count: the retrigger wins and no note_done pulse is produced.
- Reset mid-note: outputs return to reset values immediately (asynchronous), with no note_done.
- scan_valid arriving during reset deassertion is ignored until the first edge after resetn is high.

Optional Feature:
- Macro: DOTTED_NOTE_EN.
- When defined:
  - A make of keypad '.' (byte 71) in IDLE toggles an internal dotted flag. The flag resets to 0 and also pulses len_update.
  - Duration becomes ticks + (ticks>>1), latched at note_start. The counter is widened by 1 bit.
- When undefined: byte 71 is an ignored unmapped make, and durations are undotted.

Decomposition:
- Shared package synth_pkg holds:
  - scan-code constants: SC_BREAK=F0, SC_EXT=E0, SC_KEY1..SC_KEY8, SC_KP_DOT=71;
  - the prefix-state enum (IDLE, BRK, EXT, EXT_BRK);
  - a clog2 helper function.
- One sub-module, note_timer: prescaler plus tick countdown, with load value, start, active and done.
- The prefix FSM and key map stay in the top module.

Test Plan:
- Reset held, then release: length_idx=3, note_active=0, no pulses.
- Bytes 1E, then F0, 1E: idx becomes 1 with one len_update pulse; the break sequence produces no pulse and no change.
- Bytes E0, 16, then E0, F0, 16, then 5A: idx is unchanged and no len_update occurs.
- TICK_DIV=4, BASE_TICKS=1, NUM_LEN=8, idx 7, note_start: note_active high exactly 4 cycles, note_done coincides with its last cycle. Repeat at idx 0: 512 cycles.
- Same parameters, idx 6, note_start at t0, then a second note_start at t0+5: active continuously until t0+5+8, with a single note_done.
- With DOTTED_NOTE_EN, idx 6, byte 71, then note_start: active for 12 cycles. A second 71 restores 8 cycles.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared definitions for the DE2 synthesizer keyboard path: PS/2 scan-code
// constants, the make/break/extended prefix state encoding and a constant
// ceil(log2) helper used to size counters.
package synth_pkg;

    // Prefix bytes of the PS/2 set-2 protocol
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;

    // Digit keys 1..8 on the main keyboard row
    localparam logic [7:0] SC_KEY1   = 8'h16;
    localparam logic [7:0] SC_KEY2   = 8'h1E;
    localparam logic [7:0] SC_KEY3   = 8'h26;
    localparam logic [7:0] SC_KEY4   = 8'h25;
    localparam logic [7:0] SC_KEY5   = 8'h2E;
    localparam logic [7:0] SC_KEY6   = 8'h36;
    localparam logic [7:0] SC_KEY7   = 8'h3D;
    localparam logic [7:0] SC_KEY8   = 8'h3E;

    // Keypad '.' (dotted-note toggle when that feature is built in)
    localparam logic [7:0] SC_KP_DOT = 8'h71;

    // Where we are inside a multi-byte scan-code sequence
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } prefix_state_e;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/note_timer.sv
// Note duration timer: a prescaler divides clk into duration ticks and a tick
// counter counts the latched load value down. active_o is high for exactly
// load_i * TICK_DIV cycles after a start; done_o marks the last of them.
// A start while running reloads both counters (retrigger) and suppresses done.
module note_timer #(
    parameter int TICK_DIV = 12500,
    parameter int PW       = 14,
    parameter int TW       = 12
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start_i,
    input  logic [TW-1:0] load_i,
    output logic          active_o,
    output logic          done_o
);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic          active_q, active_d;
    logic [PW-1:0] presc_q,  presc_d;
    logic [TW-1:0] ticks_q,  ticks_d;
    logic          last_cycle;

    // Final cycle of a note: one tick left and the prescaler about to wrap.
    // A load of 0 is treated like 1 so the timer can never run away.
    assign last_cycle = active_q && (ticks_q <= TW'(1)) && (presc_q == '0);

    // Timer state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active_q <= 1'b0;
            presc_q  <= '0;
            ticks_q  <= '0;
        end else begin
            active_q <= active_d;
            presc_q  <= presc_d;
            ticks_q  <= ticks_d;
        end
    end

    // Load on start, otherwise count the prescaler and ticks down
    always_comb begin
        active_d = active_q;
        presc_d  = presc_q;
        ticks_d  = ticks_q;
        if (start_i) begin
            active_d = 1'b1;
            presc_d  = PRESC_MAX;
            ticks_d  = load_i;
        end else if (active_q) begin
            if (last_cycle) begin
                active_d = 1'b0;
                presc_d  = '0;
                ticks_d  = '0;
            end else if (presc_q == '0) begin
                presc_d = PRESC_MAX;
                ticks_d = ticks_q - TW'(1);
            end else begin
                presc_d = presc_q - PW'(1);
            end
        end
    end

    assign active_o = active_q;
    // A retrigger landing on the terminal cycle wins over the done pulse
    assign done_o   = last_cycle && !start_i;

endmodule

// File: rtl/note_length_sequencer.sv
// Note-length sequencer: decodes the PS/2 byte stream (make/break/extended
// prefixes) into a registered note-length index and times notes with
// note_timer. Optional build macro DOTTED_NOTE_EN adds a keypad-'.' dotted
// flag that stretches each latched duration by half.
module note_length_sequencer
    import synth_pkg::*;
#(
    parameter int NUM_LEN     = 8,
    parameter int LEN_W       = 3,
    parameter int DEFAULT_IDX = 3,
    parameter int TICK_DIV    = 12500,
    parameter int BASE_TICKS  = 25
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       scan_code,
    input  logic             scan_valid,
    input  logic             note_start,
    output logic [LEN_W-1:0] length_idx,
    output logic             len_update,
    output logic             note_active,
    output logic             note_done
);

    // Tick count of the longest note; dotting adds up to half again
    localparam int MAX_TICKS = BASE_TICKS << (NUM_LEN - 1);
`ifdef DOTTED_NOTE_EN
    localparam int TW = clog2(MAX_TICKS + 1) + 1;
`else
    localparam int TW = clog2(MAX_TICKS + 1);
`endif
    localparam int PW = (clog2(TICK_DIV) < 1) ? 1 : clog2(TICK_DIV);

    prefix_state_e    state_q, state_d;
    logic [LEN_W-1:0] length_idx_q, length_idx_d;
    logic             len_update_q, len_update_d;
    logic             key_hit;
    logic [3:0]       key_idx;
    logic [LEN_W-1:0] shift_amt;
    logic [TW-1:0]    base_ticks;
    logic [TW-1:0]    load_ticks;
`ifdef DOTTED_NOTE_EN
    logic             dotted_q, dotted_d;
`endif

    // Digit-key map; anything else is an unmapped make code
    always_comb begin
        key_hit = 1'b1;
        key_idx = 4'd0;
        case (scan_code)
            SC_KEY1: key_idx = 4'd0;
            SC_KEY2: key_idx = 4'd1;
            SC_KEY3: key_idx = 4'd2;
            SC_KEY4: key_idx = 4'd3;
            SC_KEY5: key_idx = 4'd4;
            SC_KEY6: key_idx = 4'd5;
            SC_KEY7: key_idx = 4'd6;
            SC_KEY8: key_idx = 4'd7;
            default: key_hit = 1'b0;
        endcase
    end

    // Prefix state, selected length and update pulse registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            length_idx_q <= LEN_W'(DEFAULT_IDX);
            len_update_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            length_idx_q <= length_idx_d;
            len_update_q <= len_update_d;
        end
    end

`ifdef DOTTED_NOTE_EN
    // Dotted-note flag register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dotted_q <= 1'b0;
        end else begin
            dotted_q <= dotted_d;
        end
    end
`endif

    // Prefix FSM: only a plain make code in IDLE may change the selection
    always_comb begin
        state_d      = state_q;
        length_idx_d = length_idx_q;
        len_update_d = 1'b0;
`ifdef DOTTED_NOTE_EN
        dotted_d     = dotted_q;
`endif
        if (scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else if (scan_code == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (key_hit && (int'(key_idx) < NUM_LEN)) begin
                        length_idx_d = LEN_W'(key_idx);
                        len_update_d = 1'b1;
                    end
`ifdef DOTTED_NOTE_EN
                    else if (scan_code == SC_KP_DOT) begin
                        dotted_d     = !dotted_q;
                        len_update_d = 1'b1;
                    end
`endif
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                end
                ST_EXT: begin
                    state_d = (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Index 0 is the longest note: shift the base count up by NUM_LEN-1-idx
    assign shift_amt  = LEN_W'(NUM_LEN - 1) - length_idx_q;
    assign base_ticks = TW'(BASE_TICKS) << shift_amt;
`ifdef DOTTED_NOTE_EN
    assign load_ticks = dotted_q ? (base_ticks + (base_ticks >> 1)) : base_ticks;
`else
    assign load_ticks = base_ticks;
`endif

    note_timer #(
        .TICK_DIV (TICK_DIV),
        .PW       (PW),
        .TW       (TW)
    ) u_note_timer (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (note_start),
        .load_i   (load_ticks),
        .active_o (note_active),
        .done_o   (note_done)
    );

    assign length_idx = length_idx_q;
    assign len_update = len_update_q;

endmodule

// File: tb/tb_note_length_sequencer.sv
// Bench for note_length_sequencer with TICK_DIV=4, BASE_TICKS=1, NUM_LEN=8:
// a scan-byte vector table plus note-timing sequences (retrigger, terminal
// retrigger, key in the start cycle, dotted notes, reset mid-note).
module tb_note_length_sequencer;

    localparam int NUM_LEN    = 8;
    localparam int LEN_W      = 3;
    localparam int DEF_IDX    = 3;
    localparam int TICK_DIV   = 4;
    localparam int BASE_TICKS = 1;
`ifdef DOTTED_NOTE_EN
    localparam logic DOT_UPD  = 1'b1;
    localparam int   DOT_LEN6 = 12;
`else
    localparam logic DOT_UPD  = 1'b0;
    localparam int   DOT_LEN6 = 8;
`endif

    logic             clk;
    logic             resetn;
    logic [7:0]       scan_code;
    logic             scan_valid;
    logic             note_start;
    logic [LEN_W-1:0] length_idx;
    logic             len_update;
    logic             note_active;
    logic             note_done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]       code;
        logic [LEN_W-1:0] exp_idx;
        logic             exp_upd;
    } vec_t;

    typedef struct {
        logic [LEN_W-1:0] idx;
        logic             upd;
    } exp_t;

    vec_t vecs[16];
    exp_t key_sb[$];
    int   note_sb[$];

    note_length_sequencer #(
        .NUM_LEN     (NUM_LEN),
        .LEN_W       (LEN_W),
        .DEFAULT_IDX (DEF_IDX),
        .TICK_DIV    (TICK_DIV),
        .BASE_TICKS  (BASE_TICKS)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .note_start  (note_start),
        .length_idx  (length_idx),
        .len_update  (len_update),
        .note_active (note_active),
        .note_done   (note_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // One scan byte; outputs checked in the cycle after it is sampled
    task automatic send_byte(input logic [7:0] code);
        @(posedge clk);
        #1;
        scan_code  = code;
        scan_valid = 1'b1;
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
    endtask

    task automatic key_vec(input string name, input logic [7:0] code,
                           input logic [LEN_W-1:0] eidx, input logic eupd);
        exp_t e;
        key_sb.push_back('{idx: eidx, upd: eupd});
        send_byte(code);
        e = key_sb.pop_front();
        check($sformatf("%s byte %h idx", name, code), int'(length_idx), int'(e.idx));
        check($sformatf("%s byte %h upd", name, code), int'(len_update), int'(e.upd));
    endtask

    // Start a note; optionally retrigger during active cycle retrig_at and
    // optionally present a key byte in the same cycle as the start.
    task automatic run_note(input string name, input int exp_cycles, input int retrig_at,
                            input bit key_en, input logic [7:0] key);
        int cnt;
        int dones;
        int done_at;
        int expv;
        bit finished;
        cnt = 0;
        dones = 0;
        done_at = -1;
        finished = 1'b0;
        @(posedge clk);
        #1;
        note_start = 1'b1;
        if (key_en) begin
            scan_code  = key;
            scan_valid = 1'b1;
        end
        note_sb.push_back(exp_cycles);
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk);
            #1;
            note_start = (retrig_at != 0) && (k == retrig_at);
            scan_valid = 1'b0;
            #1;
            if (note_active) cnt++;
            if (note_done) begin
                dones++;
                done_at = k;
            end
            if (!note_active) begin
                finished = 1'b1;
                break;
            end
        end
        expv = note_sb.pop_front();
        check({name, " finished"}, int'(finished), 1);
        check({name, " active cycles"}, cnt, expv);
        check({name, " done pulses"}, dones, 1);
        check({name, " done cycle"}, done_at, expv);
    endtask

    initial begin
        resetn     = 1'b0;
        scan_code  = 8'h00;
        scan_valid = 1'b0;
        note_start = 1'b0;

        vecs[0]  = '{8'h1E, 3'd1, 1'b1};
        vecs[1]  = '{8'hF0, 3'd1, 1'b0};
        vecs[2]  = '{8'h1E, 3'd1, 1'b0};
        vecs[3]  = '{8'hE0, 3'd1, 1'b0};
        vecs[4]  = '{8'h16, 3'd1, 1'b0};
        vecs[5]  = '{8'hE0, 3'd1, 1'b0};
        vecs[6]  = '{8'hF0, 3'd1, 1'b0};
        vecs[7]  = '{8'h16, 3'd1, 1'b0};
        vecs[8]  = '{8'h5A, 3'd1, 1'b0};
        vecs[9]  = '{8'h3E, 3'd7, 1'b1};
        vecs[10] = '{8'h3E, 3'd7, 1'b1};
        vecs[11] = '{8'h71, 3'd7, DOT_UPD};
        vecs[12] = '{8'h71, 3'd7, DOT_UPD};
        vecs[13] = '{8'h25, 3'd3, 1'b1};
        vecs[14] = '{8'h16, 3'd0, 1'b1};
        vecs[15] = '{8'h3D, 3'd6, 1'b1};

        repeat (3) @(posedge clk);
        check("in reset idx", int'(length_idx), DEF_IDX);
        check("in reset active", int'(note_active), 0);
        #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("after reset idx", int'(length_idx), DEF_IDX);
        check("after reset upd", int'(len_update), 0);
        check("after reset active", int'(note_active), 0);
        check("after reset done", int'(note_done), 0);

        for (int i = 0; i < 16; i++) begin
            key_vec($sformatf("vec%0d", i), vecs[i].code, vecs[i].exp_idx, vecs[i].exp_upd);
        end

        // idx 7: 1 tick * 4
        key_vec("sel7", 8'h3E, 3'd7, 1'b1);
        run_note("idx7", 4, 0, 1'b0, 8'h00);
        // idx 0: 128 ticks * 4
        key_vec("sel0", 8'h16, 3'd0, 1'b1);
        run_note("idx0", 512, 0, 1'b0, 8'h00);
        // idx 6: 2 ticks * 4, then retrigger at t0+5
        key_vec("sel6", 8'h3D, 3'd6, 1'b1);
        run_note("idx6", 8, 0, 1'b0, 8'h00);
        run_note("retrig5", 13, 5, 1'b0, 8'h00);
        // retrigger exactly on the terminal cycle
        run_note("retrig_tc", 16, 8, 1'b0, 8'h00);
        // key 8 in the start cycle: the note uses old idx 6
        run_note("key_same_cycle", 8, 0, 1'b1, 8'h3E);
        check("idx after same-cycle key", int'(length_idx), 7);

        // dotted notes at idx 6
        key_vec("sel6b", 8'h3D, 3'd6, 1'b1);
        key_vec("dot_on", 8'h71, 3'd6, DOT_UPD);
        run_note("dotted", DOT_LEN6, 0, 1'b0, 8'h00);
        key_vec("dot_off", 8'h71, 3'd6, DOT_UPD);
        run_note("undotted", 8, 0, 1'b0, 8'h00);

        // reset in the middle of a note
        @(posedge clk);
        #1;
        note_start = 1'b1;
        @(posedge clk);
        #1;
        note_start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre-reset active", int'(note_active), 1);
        resetn = 1'b0;
        #1;
        check("mid reset active", int'(note_active), 0);
        check("mid reset done", int'(note_done), 0);
        check("mid reset idx", int'(length_idx), DEF_IDX);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post reset active", int'(note_active), 0);
        check("post reset idx", int'(length_idx), DEF_IDX);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
